bios_loader: RTL and testbench

Sequences the BIOS image from the `data_io` byte stream into the system core's 16-bit BIOS write port. It sits between `data_io` and the `system` instance in the MiST top level, on the `clk_sdr` domain. It pairs bytes into words and stages them in two ping-pong 32-word banks. It drains each full bank on the core's `BIOS_REQ` handshake, flags overruns, and reports when the image is fully loaded.

---
 rtl/bios_loader_pkg.sv | 16 +
 rtl/bios_bank_ram.sv | 35 +++
 rtl/bios_loader.sv | 188 ++++++++++++++++++
 tb/tb_bios_loader.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/bios_loader_pkg.sv
// bios_loader_pkg: shared drain-state type and bank geometry defaults
// for the BIOS image loader.
package bios_loader_pkg;

    typedef enum logic [1:0] {
        IDLE,
        XFER,
        DONE
    } drain_state_t;

    localparam int ADDR_W_DEF   = 13;
    localparam int BLK_LOG2_DEF = 5;
    localparam int RAM_AW_DEF   = BLK_LOG2_DEF + 1;
    localparam int WORD_W       = 16;

endpackage

// File: rtl/bios_bank_ram.sv
// bios_bank_ram: simple dual-port RAM holding both ping-pong banks,
// one fill write port and one registered drain read port.
module bios_bank_ram
    import bios_loader_pkg::*;
#(
    parameter int AW = RAM_AW_DEF,
    parameter int DW = WORD_W
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic          re,
    input  logic [AW-1:0] raddr,
    output logic [DW-1:0] rdata
);

    logic [DW-1:0] mem [0:(1<<AW)-1];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rdata <= '0;
        end else if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/bios_loader.sv
// bios_loader: pairs data_io bytes into words, stages them in two
// ping-pong banks and drains each full bank on the core's bios_req.
module bios_loader
    import bios_loader_pkg::*;
#(
    parameter int ADDR_W   = ADDR_W_DEF,
    parameter int BLK_LOG2 = BLK_LOG2_DEF
) (
    input  logic              clk_sys,
    input  logic              reset,
    input  logic              ioctl_download,
    input  logic              ioctl_wr,
    input  logic [24:0]       ioctl_addr,
    input  logic [7:0]        ioctl_dout,
    input  logic              bios_req,
    output logic [ADDR_W-1:0] bios_addr,
    output logic [15:0]       bios_din,
    output logic              bios_wr,
    output logic              bios_loaded,
    output logic              overrun
);

    localparam int RAM_AW = BLK_LOG2 + 1;

    drain_state_t state, state_nxt;

    logic                dl_q;
    logic                req_q;
    logic                seen_fall;
    logic                first_word;
    logic                fill_bank;
    logic                rd_bank;
    logic                wr_nxt;
    logic [7:0]          low_byte;
    logic [1:0]          full;
    logic [1:0]          dirty;
    logic [1:0]          full_set;
    logic [1:0]          full_clr;
    logic [1:0]          dirty_set;
    logic [BLK_LOG2-1:0] idx;

    logic dl_rise;
    logic dl_fall;
    logic restart;
    logic fill;
    logic odd_wr;
    logic wr_bank;
    logic last_word;
    logic xfer_rd;
    logic drain_done;
    logic loaded_cond;
    logic unused_addr;

    assign dl_rise     = ioctl_download & ~dl_q;
    assign dl_fall     = ~ioctl_download & dl_q;
    assign restart     = reset | dl_rise;
    assign fill        = ioctl_download & ioctl_wr & ~dl_rise;
    assign odd_wr      = fill & ioctl_addr[0];
    assign wr_bank     = ioctl_addr[BLK_LOG2+1];
    assign last_word   = odd_wr & (&ioctl_addr[BLK_LOG2:1]);
    assign xfer_rd     = (state == XFER) & bios_req;
    assign drain_done  = (state == DONE) & req_q & ~bios_req;
    assign unused_addr = ^ioctl_addr[24:BLK_LOG2+2];

    // dl_q gate keeps a pending flush from racing the loaded check
    assign loaded_cond = ~ioctl_download & ~dl_q & ~(|full)
                       & (state == IDLE) & seen_fall;

    assign dirty_set = {odd_wr & wr_bank, odd_wr & ~wr_bank};

    always_comb begin
        full_set = '0;
        full_clr = '0;
        for (int b = 0; b < 2; b++) begin
            full_set[b] = (last_word & (wr_bank == 1'(b)))
                        | (dl_fall & dirty[b] & (fill_bank == 1'(b)));
            full_clr[b] = drain_done & (rd_bank == 1'(b));
        end
    end

    always_comb begin
        state_nxt = state;
        wr_nxt    = bios_wr;
        unique case (state)
            IDLE: begin
                if (full[rd_bank]) begin
                    state_nxt = XFER;
                    wr_nxt    = 1'b1;
                end
            end
            XFER: begin
                if (bios_req && (&idx)) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                if (drain_done) begin
                    state_nxt = IDLE;
                    wr_nxt    = 1'b0;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            dl_q      <= 1'b0;
            req_q     <= 1'b0;
            seen_fall <= 1'b0;
            low_byte  <= '0;
            fill_bank <= 1'b0;
        end else begin
            dl_q  <= ioctl_download;
            req_q <= bios_req;
            if (dl_fall) begin
                seen_fall <= 1'b1;
            end
            if (fill) begin
                fill_bank <= wr_bank;
                if (!ioctl_addr[0]) begin
                    low_byte <= ioctl_dout;
                end
            end
        end
    end

    always_ff @(posedge clk_sys) begin
        if (restart) begin
            full    <= '0;
            dirty   <= '0;
            overrun <= 1'b0;
        end else begin
            full  <= (full & ~full_clr) | full_set;
            dirty <= (dirty & ~full_clr) | dirty_set;
            if (fill && full[wr_bank]) begin
                overrun <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk_sys) begin
        if (restart) begin
            state      <= IDLE;
            bios_wr    <= 1'b0;
            idx        <= '0;
            rd_bank    <= 1'b0;
            bios_addr  <= '0;
            first_word <= 1'b1;
        end else begin
            state   <= state_nxt;
            bios_wr <= wr_nxt;
            if (xfer_rd) begin
                idx        <= idx + 1'b1;
                first_word <= 1'b0;
                if (!first_word) begin
                    bios_addr <= bios_addr + 1'b1;
                end
            end
            if (drain_done) begin
                rd_bank <= ~rd_bank;
            end
        end
    end

    always_ff @(posedge clk_sys) begin
        if (restart) begin
            bios_loaded <= 1'b0;
        end else if (loaded_cond) begin
            bios_loaded <= 1'b1;
        end
    end

    bios_bank_ram #(
        .AW (RAM_AW),
        .DW (16)
    ) u_ram (
        .clk   (clk_sys),
        .rst   (reset),
        .we    (odd_wr),
        .waddr ({wr_bank, ioctl_addr[BLK_LOG2:1]}),
        .wdata ({ioctl_dout, low_byte}),
        .re    (xfer_rd),
        .raddr ({rd_bank, idx}),
        .rdata (bios_din)
    );

endmodule

// File: tb/tb_bios_loader.sv
// tb_bios_loader: directed checks of the BIOS loader, with a second
// instance at ADDR_W=6 to observe address wrap.
module tb_bios_loader;

    logic        clk = 1'b0;
    logic        reset;
    logic        ioctl_download;
    logic        ioctl_wr;
    logic [24:0] ioctl_addr;
    logic [7:0]  ioctl_dout;
    logic        bios_req;

    logic [12:0] addr1;
    logic [15:0] din1;
    logic        wr1, loaded1, ovr1;
    logic [5:0]  addr2;
    logic [15:0] din2;
    logic        wr2, loaded2, ovr2;

    int n_chk = 0;
    int n_err = 0;
    int nw    = 0;

    logic [12:0] ga1 [256];
    logic [15:0] gd1 [256];
    logic [5:0]  ga2 [256];
    logic [15:0] gd2 [256];

    always #5 clk = ~clk;

    bios_loader u_dut (
        .clk_sys        (clk),
        .reset          (reset),
        .ioctl_download (ioctl_download),
        .ioctl_wr       (ioctl_wr),
        .ioctl_addr     (ioctl_addr),
        .ioctl_dout     (ioctl_dout),
        .bios_req       (bios_req),
        .bios_addr      (addr1),
        .bios_din       (din1),
        .bios_wr        (wr1),
        .bios_loaded    (loaded1),
        .overrun        (ovr1)
    );

    bios_loader #(.ADDR_W(6)) u_dut_w (
        .clk_sys        (clk),
        .reset          (reset),
        .ioctl_download (ioctl_download),
        .ioctl_wr       (ioctl_wr),
        .ioctl_addr     (ioctl_addr),
        .ioctl_dout     (ioctl_dout),
        .bios_req       (bios_req),
        .bios_addr      (addr2),
        .bios_din       (din2),
        .bios_wr        (wr2),
        .bios_loaded    (loaded2),
        .overrun        (ovr2)
    );

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic send_byte(input int a, input logic [7:0] d);
        @(negedge clk);
        ioctl_wr   = 1'b1;
        ioctl_addr = 25'(a);
        ioctl_dout = d;
        @(negedge clk);
        ioctl_wr   = 1'b0;
    endtask

    task automatic wait_wr(input string tag);
        int t = 0;
        while (!wr1 && t < 400) begin
            @(negedge clk);
            t++;
        end
        check({tag, "_wr_rise"}, 32'(wr1), 32'd1);
    endtask

    task automatic core_words(input int n);
        for (int i = 0; i < n; i++) begin
            bios_req = 1'b1;
            @(negedge clk);
            bios_req = 1'b0;
            ga1[nw] = addr1;
            gd1[nw] = din1;
            ga2[nw] = addr2;
            gd2[nw] = din2;
            nw++;
            @(negedge clk);
        end
    endtask

    task automatic drain_bank(input string tag);
        wait_wr(tag);
        core_words(32);
        check({tag, "_wr_drop1"}, 32'(wr1), 32'd0);
        check({tag, "_wr_drop2"}, 32'(wr2), 32'd0);
    endtask

    task automatic start_dl();
        @(negedge clk);
        ioctl_download = 1'b1;
        nw = 0;
        @(negedge clk);
    endtask

    task automatic end_dl();
        @(negedge clk);
        ioctl_download = 1'b0;
        @(negedge clk);
        @(negedge clk);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset          = 1'b1;
        ioctl_download = 1'b0;
        ioctl_wr       = 1'b0;
        ioctl_addr     = '0;
        ioctl_dout     = '0;
        bios_req       = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_wr", 32'(wr1), 32'd0);
        check("rst_addr", 32'(addr1), 32'd0);
        check("rst_din", 32'(din1), 32'd0);
        check("rst_loaded", 32'(loaded1), 32'd0);
        check("rst_ovr", 32'(ovr1), 32'd0);
        reset = 1'b0;

        // A: 128 bytes, byte value = address
        start_dl();
        for (int a = 0; a < 128; a++) begin
            send_byte(a, 8'(a));
            if (a == 63) begin
                check("A_lat_wr0", 32'(wr1), 32'd0);
                @(negedge clk);
                check("A_lat_wr1", 32'(wr1), 32'd1);
            end
        end
        check("A_ovr", 32'(ovr1), 32'd0);
        end_dl();
        check("A_loaded_early", 32'(loaded1), 32'd0);
        drain_bank("A0");
        drain_bank("A1");
        @(negedge clk);
        @(negedge clk);
        check("A_loaded", 32'(loaded1), 32'd1);
        check("A_word1", 32'(gd1[1]), 32'h0302);
        for (int i = 0; i < 64; i++) begin
            check("A_addr", 32'(ga1[i]), 32'(i));
            check("A_data", 32'(gd1[i]),
                  32'({8'(2*i+1), 8'(2*i)}));
        end

        // B: second download of 70 bytes, value = address + 0x40
        @(negedge clk);
        ioctl_download = 1'b1;
        nw = 0;
        @(negedge clk);
        check("B_loaded_drop", 32'(loaded1), 32'd0);
        for (int a = 0; a < 70; a++) begin
            send_byte(a, 8'(a + 8'h40));
        end
        end_dl();
        check("B_loaded_early", 32'(loaded1), 32'd0);
        drain_bank("B0");
        drain_bank("B1");
        @(negedge clk);
        @(negedge clk);
        check("B_loaded", 32'(loaded1), 32'd1);
        check("B_w0_addr", 32'(ga1[0]), 32'd0);
        check("B_w0_data", 32'(gd1[0]), 32'h4140);
        check("B_w32", 32'(gd1[32]), 32'h8180);
        check("B_w33", 32'(gd1[33]), 32'h8382);
        check("B_w34", 32'(gd1[34]), 32'h8584);
        check("B_w34_addr", 32'(ga1[34]), 32'd34);
        check("B_last_addr", 32'(ga1[63]), 32'd63);
        check("B_count", 32'(nw), 32'd64);

        // C: core stalled while a third bank arrives
        start_dl();
        for (int a = 0; a < 128; a++) begin
            send_byte(a, 8'(a));
        end
        check("C_wr_stall", 32'(wr1), 32'd1);
        check("C_ovr_pre", 32'(ovr1), 32'd0);
        send_byte(128, 8'h80);
        check("C_ovr", 32'(ovr1), 32'd1);
        check("C_ovr_w", 32'(ovr2), 32'd1);
        @(negedge clk);
        ioctl_download = 1'b0;
        @(negedge clk);
        check("C_ovr_held", 32'(ovr1), 32'd1);
        ioctl_download = 1'b1;
        @(negedge clk);
        check("C_ovr_clr", 32'(ovr1), 32'd0);

        // D: reset in the middle of a bank transfer
        nw = 0;
        for (int a = 0; a < 64; a++) begin
            send_byte(a, 8'(a));
        end
        wait_wr("D");
        core_words(10);
        check("D_addr_pre", 32'(ga1[9]), 32'd9);
        reset = 1'b1;
        @(negedge clk);
        check("D_wr", 32'(wr1), 32'd0);
        check("D_addr", 32'(addr1), 32'd0);
        check("D_loaded", 32'(loaded1), 32'd0);
        check("D_din", 32'(din1), 32'd0);
        reset          = 1'b0;
        ioctl_download = 1'b0;
        repeat (3) @(negedge clk);

        // E: 256-byte image, address wrap on the ADDR_W=6 instance
        start_dl();
        for (int a = 0; a < 128; a++) begin
            send_byte(a, 8'(a));
        end
        drain_bank("E0");
        drain_bank("E1");
        for (int a = 128; a < 256; a++) begin
            send_byte(a, 8'(a));
        end
        drain_bank("E2");
        drain_bank("E3");
        end_dl();
        @(negedge clk);
        check("E_loaded1", 32'(loaded1), 32'd1);
        check("E_loaded2", 32'(loaded2), 32'd1);
        check("E_w64_addr2", 32'(ga2[64]), 32'd0);
        check("E_w64_data2", 32'(gd2[64]), 32'h8180);
        check("E_w63_addr2", 32'(ga2[63]), 32'd63);
        check("E_w127_addr2", 32'(ga2[127]), 32'd63);
        check("E_w127_data2", 32'(gd2[127]), 32'hFFFE);
        check("E_w64_addr1", 32'(ga1[64]), 32'd64);
        check("E_w127_addr1", 32'(ga1[127]), 32'd127);
        for (int i = 0; i < 128; i += 8) begin
            check("E_addr2", 32'(ga2[i]), 32'(i % 64));
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
